// File: rtl/mod_n_event_div_if.sv
// Signal bundle for mod_n_event_div: count controls and event input in, count state out.
// The master drives EN/CLR/X/DIV_N and observes Z/CNT/ZCNT; the slave is the divider itself.
interface mod_n_event_div_if #(
  parameter int CNT_W = 4
);
  // No valid/ready handshake: every signal is a level sampled on each rising
  // clock edge, so X must be synchronous to the divider clock.
  logic             EN;
  logic             CLR;
  logic             X;
  logic [CNT_W-1:0] DIV_N;
  logic             Z;
  logic [CNT_W-1:0] CNT;
  logic [7:0]       ZCNT;

  modport master (
    output EN, CLR, X, DIV_N,
    input  Z, CNT, ZCNT
  );

  modport slave (
    input  EN, CLR, X, DIV_N,
    output Z, CNT, ZCNT
  );
endinterface

// File: rtl/mod_n_event_div.sv
// Modulo-N event divider: one-cycle Z pulse every MOD events, with saturating pulse counter.
// Define MOD_N_EDGE_DET_EN to count rising edges of X instead of cycles with X high.
module mod_n_event_div #(
  parameter int CNT_W = 4,
  parameter int DEF_N = 3
) (
  input  logic                 CLK_50M,
  input  logic                 RST_N,
  mod_n_event_div_if.slave     bus
);

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_MOD = CNT_W'(DEF_N);
  localparam logic [7:0]       ZCNT_MAX = 8'hFF;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] mod_q;
  logic             z_q;
  logic [7:0]       zcnt_q;

  logic             x_qual;
  logic             ev;
  logic             last;
  logic [CNT_W-1:0] reload;

`ifdef MOD_N_EDGE_DET_EN
  logic x_d;

  // Tracks X on every edge regardless of EN/CLR so an edge is never missed or doubled.
  always_ff @(posedge CLK_50M) begin
    if (!RST_N) x_d <= 1'b0;
    else        x_d <= bus.X;
  end

  assign x_qual = bus.X && !x_d;
`else
  assign x_qual = bus.X;
`endif

  always_comb begin
    ev     = bus.EN && x_qual;
    last   = (cnt_q == (mod_q - ONE));
    // Moduli below 2 cannot produce a sane count sequence, so fall back to the power-up value.
    reload = (bus.DIV_N >= TWO) ? bus.DIV_N : DEF_MOD;
  end

  always_ff @(posedge CLK_50M) begin
    if (!RST_N) begin
      cnt_q  <= '0;
      mod_q  <= DEF_MOD;
      z_q    <= 1'b0;
      zcnt_q <= '0;
    end else if (bus.CLR) begin
      cnt_q  <= '0;
      mod_q  <= reload;
      z_q    <= 1'b0;
      zcnt_q <= '0;
    end else begin
      z_q <= ev && last;
      if (ev) begin
        if (last) begin
          cnt_q <= '0;
          mod_q <= reload;
          if (zcnt_q != ZCNT_MAX) zcnt_q <= zcnt_q + 8'd1;
        end else begin
          cnt_q <= cnt_q + ONE;
        end
      end
    end
  end

  assign bus.CNT  = cnt_q;
  assign bus.Z    = z_q;
  assign bus.ZCNT = zcnt_q;

endmodule
